stopwatch_core: RTL and testbench

Timekeeping and control stage that sits directly downstream of the per-button debouncers. It takes the clean start/stop, lap and clear levels and detects their rising edges. It runs a run/pause/lap state machine and advances a 6-digit BCD time count (MM:SS.cc) at a prescaled centisecond rate. Its outputs drive the display-multiplex stage.

---
 rtl/stopwatch_core.sv | 192 +++++++++++++++++++
 tb/tb_stopwatch_core.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// stopwatch_core
//   Timekeeping/control stage behind the button debouncers. Detects rising
//   edges of the clean start/stop, lap and clear levels, runs the
//   IDLE/RUN/PAUSE/LAP state machine and advances a 6-digit BCD time count
//   (MM:SS.cc) once per prescaled centisecond tick.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   start_stop  debounced start/stop level
//   lap         debounced lap level
//   clear       debounced clear level
//   digits      {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones}, BCD
//   running     high in RUN and LAP
//   lap_active  high in LAP (display frozen on the lap register)
//   overflow    sticky, set when the time wraps past 59:59.99
module stopwatch_core #(
   parameter int TICK_DIV = 1000000,
   parameter int PRE_W    = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_stop,
   input  logic        lap,
   input  logic        clear,
   output logic [23:0] digits,
   output logic        running,
   output logic        lap_active,
   output logic        overflow
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;

   state_t state_q, state_d;

   logic ss_prev_q, ss_prev_d;
   logic lap_prev_q, lap_prev_d;
   logic clr_prev_q, clr_prev_d;
   logic ev_clr, ev_ss, ev_lap;

   logic [PRE_W-1:0] pre_q, pre_d;
   logic             counting, tick;
   logic [23:0]      time_q, time_d;
   logic [23:0]      lap_reg_q, lap_reg_d;
   logic [24:0]      time_inc;
   logic             overflow_q, overflow_d;
   logic             running_q, running_d;
   logic             lap_active_q, lap_active_d;
   logic             do_clear, do_lap_latch;

   // One-centisecond BCD increment. Bit 24 of the result flags the wrap
   // from 59:59.99 to 00:00.00. Digit 3 (s_tens) and 5 (m_tens) roll at 5.
   function automatic logic [24:0] bcd_inc(input logic [23:0] t);
      logic [23:0] r;
      logic        c;
      logic [3:0]  lim;
      r = t;
      c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
         if (c) begin
            if (r[i*4 +: 4] == lim) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return {c, r};
   endfunction

   // Edge detect with fixed priority clear > start_stop > lap; a losing
   // edge is dropped for good, not deferred to a later cycle.
   always_comb begin
      ss_prev_d  = start_stop;
      lap_prev_d = lap;
      clr_prev_d = clear;
      ev_clr = clear & ~clr_prev_q;
      ev_ss  = start_stop & ~ss_prev_q & ~ev_clr;
      ev_lap = lap & ~lap_prev_q & ~ev_clr & ~ev_ss;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      do_clear     = 1'b0;
      do_lap_latch = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ev_ss) state_d = S_RUN;
         end
         S_RUN: begin
            if (ev_ss) begin
               state_d = S_PAUSE;
            end else if (ev_lap) begin
               state_d      = S_LAP;
               do_lap_latch = 1'b1;
            end
         end
         S_LAP: begin
            if (ev_ss)       state_d = S_PAUSE;
            else if (ev_lap) state_d = S_RUN;
         end
         S_PAUSE: begin
            if (ev_clr) begin
               state_d  = S_IDLE;
               do_clear = 1'b1;
            end else if (ev_ss) begin
               state_d = S_RUN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: status flags follow the next state so they are correct
   // in the first cycle of the new state.
   always_comb begin
      running_d    = (state_d == S_RUN) || (state_d == S_LAP);
      lap_active_d = (state_d == S_LAP);
      digits       = (state_q == S_LAP) ? lap_reg_q : time_q;
      running      = running_q;
      lap_active   = lap_active_q;
      overflow     = overflow_q;
   end

   // Prescaler and time count. The tick is qualified by the current state,
   // so a tick landing on a pause edge still counts. PAUSE keeps the
   // prescaler residue.
   always_comb begin
      counting = (state_q == S_RUN) || (state_q == S_LAP);
      tick     = counting && (pre_q == PRE_W'(TICK_DIV - 1));
      time_inc = bcd_inc(time_q);

      pre_d      = pre_q;
      time_d     = time_q;
      overflow_d = overflow_q;
      lap_reg_d  = do_lap_latch ? time_q : lap_reg_q;

      if (counting) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
      end
      if (tick) begin
         time_d = time_inc[23:0];
         if (time_inc[24]) overflow_d = 1'b1;
      end
      if (do_clear) begin
         pre_d      = '0;
         time_d     = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // History at 1: a button held through reset release is not an edge.
         ss_prev_q    <= 1'b1;
         lap_prev_q   <= 1'b1;
         clr_prev_q   <= 1'b1;
         pre_q        <= '0;
         time_q       <= '0;
         overflow_q   <= 1'b0;
         running_q    <= 1'b0;
         lap_active_q <= 1'b0;
      end else begin
         ss_prev_q    <= ss_prev_d;
         lap_prev_q   <= lap_prev_d;
         clr_prev_q   <= clr_prev_d;
         pre_q        <= pre_d;
         time_q       <= time_d;
         overflow_q   <= overflow_d;
         running_q    <= running_d;
         lap_active_q <= lap_active_d;
      end
   end

   // Lap register only matters while in LAP, which always loads it first.
   always_ff @(posedge clk) begin
      lap_reg_q <= lap_reg_d;
   end

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

   logic        clk;
   logic        rst;
   logic        start_stop;
   logic        lap;
   logic        clear;
   logic [23:0] digits;
   logic        running;
   logic        lap_active;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   stopwatch_core #(.TICK_DIV(4), .PRE_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_stop (start_stop),
      .lap        (lap),
      .clear      (clear),
      .digits     (digits),
      .running    (running),
      .lap_active (lap_active),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ss;
      logic        lp;
      logic        clr;
      int          n;
      logic [23:0] dig;
      logic        run;
      logic        lapa;
      logic        ovf;
   } row_t;

   row_t rows[$];

   task automatic add_row(input logic ss, input logic lp, input logic clr, input int n,
                          input logic [23:0] dig, input logic run, input logic lapa,
                          input logic ovf);
      row_t r;
      r.ss = ss; r.lp = lp; r.clr = clr; r.n = n;
      r.dig = dig; r.run = run; r.lapa = lapa; r.ovf = ovf;
      rows.push_back(r);
   endtask

   // Called at a negedge: drive inputs, let n posedges pass, return at negedge.
   task automatic apply(input logic ss, input logic lp, input logic clr, input int n);
      start_stop = ss;
      lap        = lp;
      clear      = clr;
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [23:0] dig, input logic run,
                        input logic lapa, input logic ovf);
      total++;
      if (digits !== dig) begin
         bad++;
         $display("FAIL %s digits got=%h want=%h", tag, digits, dig);
      end
      total++;
      if (running !== run) begin
         bad++;
         $display("FAIL %s running got=%b want=%b", tag, running, run);
      end
      total++;
      if (lap_active !== lapa) begin
         bad++;
         $display("FAIL %s lap_active got=%b want=%b", tag, lap_active, lapa);
      end
      total++;
      if (overflow !== ovf) begin
         bad++;
         $display("FAIL %s overflow got=%b want=%b", tag, overflow, ovf);
      end
   endtask

   initial begin
      //       ss lp cl  n     digits      run lap ovf
      add_row(1, 0, 0, 20,   24'h000000, 0, 0, 0);  // held through reset: no edge
      add_row(0, 0, 0, 1,    24'h000000, 0, 0, 0);
      add_row(1, 0, 0, 1,    24'h000000, 1, 0, 0);  // start
      add_row(0, 0, 0, 399,  24'h000099, 1, 0, 0);
      add_row(0, 0, 0, 1,    24'h000100, 1, 0, 0);  // 400 cycles -> 00:01.00
      add_row(0, 0, 0, 2,    24'h000100, 1, 0, 0);  // residue 2
      add_row(1, 0, 0, 1,    24'h000100, 0, 0, 0);  // pause, residue 3
      add_row(0, 0, 0, 10,   24'h000100, 0, 0, 0);
      add_row(1, 0, 0, 1,    24'h000100, 1, 0, 0);  // resume
      add_row(0, 0, 0, 1,    24'h000101, 1, 0, 0);  // tick after one cycle
      add_row(0, 0, 0, 4532, 24'h001234, 1, 0, 0);
      add_row(0, 1, 0, 1,    24'h001234, 1, 1, 0);  // lap
      add_row(0, 0, 0, 40,   24'h001234, 1, 1, 0);  // frozen, live at 12.44
      add_row(1, 0, 0, 1,    24'h001244, 0, 0, 0);  // LAP -> PAUSE shows live
      add_row(0, 0, 0, 1,    24'h001244, 0, 0, 0);

      rst = 1'b1; start_stop = 1'b1; lap = 1'b0; clear = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("reset", 24'h000000, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < rows.size(); i++) begin
         apply(rows[i].ss, rows[i].lp, rows[i].clr, rows[i].n);
         check($sformatf("row%0d", i), rows[i].dig, rows[i].run, rows[i].lapa, rows[i].ovf);
      end

      // Preload 59:59.98 while paused (prescaler residue is 2).
      force dut.time_q = 24'h595998;
      @(posedge clk);
      @(negedge clk);
      release dut.time_q;
      check("preload", 24'h595998, 1'b0, 1'b0, 1'b0);
      apply(1, 0, 0, 1);
      check("wrap_resume", 24'h595998, 1'b1, 1'b0, 1'b0);
      apply(0, 0, 0, 2);
      check("wrap_99", 24'h595999, 1'b1, 1'b0, 1'b0);
      apply(0, 0, 0, 4);
      check("wrap_zero", 24'h000000, 1'b1, 1'b0, 1'b1);
      apply(1, 0, 0, 1);
      check("wrap_pause", 24'h000000, 1'b0, 1'b0, 1'b1);
      apply(0, 0, 0, 1);
      apply(0, 0, 1, 1);
      check("clear_ovf", 24'h000000, 1'b0, 1'b0, 1'b0);
      apply(0, 0, 0, 1);

      // Same-cycle clear + start_stop in PAUSE: clear wins.
      apply(1, 0, 0, 1);
      apply(0, 0, 0, 6);
      apply(1, 0, 0, 1);
      check("pause_at_1", 24'h000001, 1'b0, 1'b0, 1'b0);
      apply(0, 0, 0, 1);
      apply(1, 0, 1, 1);
      check("clr_ss_pause", 24'h000000, 1'b0, 1'b0, 1'b0);
      apply(0, 0, 0, 1);

      // Same-cycle start_stop + lap in RUN: pause, no lap.
      apply(1, 0, 0, 1);
      check("restart", 24'h000000, 1'b1, 1'b0, 1'b0);
      apply(0, 0, 0, 1);
      apply(1, 1, 0, 1);
      check("ss_lap_run", 24'h000000, 1'b0, 1'b0, 1'b0);
      apply(0, 0, 0, 1);

      // Clear while running is ignored; the tick on that cycle still lands.
      apply(1, 0, 0, 1);
      apply(0, 0, 0, 1);
      apply(0, 0, 1, 1);
      check("clr_in_run", 24'h000001, 1'b1, 1'b0, 1'b0);
      apply(0, 0, 0, 4);
      check("run_on", 24'h000002, 1'b1, 1'b0, 1'b0);

      // Reset mid-run.
      rst = 1'b1;
      apply(0, 0, 0, 1);
      check("rst_mid_run", 24'h000000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      apply(0, 0, 0, 3);
      check("after_rst", 24'h000000, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
